// File: rtl/mpu6050_reader.sv
// -----------------------------------------------------------------------------
// mpu6050_reader
//
// Sequencing controller sitting directly upstream of i2c_master. After reset it
// wakes the MPU6050 once (write PWR_MGMT_VAL to register 0x6B). It then
// periodically burst-reads the six accelerometer bytes starting at START_REG
// and publishes them as three signed 16-bit samples. Byte ordering,
// START/STOP placement, per-byte timeout and retry live here; bit-level I2C
// stays in i2c_master.
//
// Parameters:
//   SAMPLE_PERIOD  cycles between sample starts (minimum 2)
//   TIMEOUT        cycles allowed per byte before error
//   PWR_MGMT_VAL   value written to register 0x6B at init
//   START_REG      first register of the burst read
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   enable                 allow new sample cycles
//   i2c_avail              master idle and ready for a byte command
//   i2c_data_out           byte received by the master
//   i2c_avail_data_out     one-cycle pulse, i2c_data_out valid
//   i2c_start              one-cycle command strobe
//   i2c_rw                 0 = write byte, 1 = read byte (valid with strobe)
//   i2c_stop               STOP after this byte (valid with strobe)
//   i2c_data_in            byte to transmit (valid with strobe)
//   accel_x/_y/_z          signed samples, {high byte, low byte}
//   sample_valid           one-cycle pulse, new samples latched
//   busy                   high outside IDLE and WAIT_TMR
//   error                  one-cycle pulse on byte timeout
// -----------------------------------------------------------------------------
module mpu6050_reader #(
    parameter int unsigned SAMPLE_PERIOD = 500000,
    parameter int unsigned TIMEOUT       = 100000,
    parameter logic [7:0]  PWR_MGMT_VAL  = 8'h00,
    parameter logic [7:0]  START_REG     = 8'h3B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        i2c_avail,
    input  logic [7:0]  i2c_data_out,
    input  logic        i2c_avail_data_out,
    output logic        i2c_start,
    output logic        i2c_rw,
    output logic        i2c_stop,
    output logic [7:0]  i2c_data_in,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        busy,
    output logic        error
);

    localparam logic [7:0] PWR_MGMT_REG = 8'h6B;

    localparam int unsigned PW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PW-1:0] PERIOD_LOAD = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_WAKE_REG = 4'd1;
    localparam logic [3:0] S_WAKE_VAL = 4'd2;
    localparam logic [3:0] S_WAIT_TMR = 4'd3;
    localparam logic [3:0] S_PTR      = 4'd4;
    localparam logic [3:0] S_RD0      = 4'd5;
    localparam logic [3:0] S_RD1      = 4'd6;
    localparam logic [3:0] S_RD2      = 4'd7;
    localparam logic [3:0] S_RD3      = 4'd8;
    localparam logic [3:0] S_RD4      = 4'd9;
    localparam logic [3:0] S_RD5      = 4'd10;
    localparam logic [3:0] S_PUBLISH  = 4'd11;
    localparam logic [3:0] S_ERR      = 4'd12;

    logic [3:0]    state;
    logic          pending;     // strobe issued, completion not yet seen
    logic          seen_low;    // i2c_avail observed low since the write strobe
    logic [TW-1:0] byte_timer;
    logic [PW-1:0] period_cnt;
    logic [7:0]    shadow [0:5];

    // Per-state command decode
    logic       is_cmd;
    logic       is_read;
    logic       cmd_stop;
    logic [7:0] cmd_byte;
    logic [2:0] rd_idx;

    logic strobe;
    logic done;
    logic expire;

    always_comb begin
        is_cmd   = 1'b0;
        is_read  = 1'b0;
        cmd_stop = 1'b0;
        cmd_byte = '0;
        rd_idx   = '0;
        case (state)
            S_WAKE_REG: begin
                is_cmd   = 1'b1;
                cmd_byte = PWR_MGMT_REG;
            end
            S_WAKE_VAL: begin
                is_cmd   = 1'b1;
                cmd_byte = PWR_MGMT_VAL;
                cmd_stop = 1'b1;
            end
            S_PTR: begin
                is_cmd   = 1'b1;
                cmd_byte = START_REG;
            end
            S_RD0: begin
                is_cmd  = 1'b1;
                is_read = 1'b1;
                rd_idx  = 3'd0;
            end
            S_RD1: begin
                is_cmd  = 1'b1;
                is_read = 1'b1;
                rd_idx  = 3'd1;
            end
            S_RD2: begin
                is_cmd  = 1'b1;
                is_read = 1'b1;
                rd_idx  = 3'd2;
            end
            S_RD3: begin
                is_cmd  = 1'b1;
                is_read = 1'b1;
                rd_idx  = 3'd3;
            end
            S_RD4: begin
                is_cmd  = 1'b1;
                is_read = 1'b1;
                rd_idx  = 3'd4;
            end
            S_RD5: begin
                is_cmd   = 1'b1;
                is_read  = 1'b1;
                cmd_stop = 1'b1;
                rd_idx   = 3'd5;
            end
            default: ;
        endcase
    end

    // The strobe is combinational so it can fire in the first cycle of a
    // command state when the master is already idle.
    assign strobe = is_cmd && !pending && i2c_avail;

    // Completion: read bytes finish on the data pulse; writes finish when
    // i2c_avail returns high after having dropped.
    assign done = pending && (is_read ? i2c_avail_data_out : (seen_low && i2c_avail));

    // Completion in the expiry cycle wins over the timeout.
    assign expire = pending && !done && (byte_timer == TIMER_LAST);

    assign i2c_start   = strobe;
    assign i2c_rw      = strobe && is_read;
    assign i2c_stop    = strobe && cmd_stop;
    assign i2c_data_in = strobe ? cmd_byte : '0;

    assign busy = (state != S_IDLE) && (state != S_WAIT_TMR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pending      <= 1'b0;
            seen_low     <= 1'b0;
            byte_timer   <= '0;
            period_cnt   <= '0;
            accel_x      <= '0;
            accel_y      <= '0;
            accel_z      <= '0;
            sample_valid <= 1'b0;
            error        <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            error        <= 1'b0;

            // Byte handshake tracking; the timer counts the strobe cycle as 1.
            if (strobe) begin
                pending    <= 1'b1;
                seen_low   <= 1'b0;
                byte_timer <= TW'(1);
            end else if (pending) begin
                if (!i2c_avail) begin
                    seen_low <= 1'b1;
                end
                byte_timer <= byte_timer + 1'b1;
            end

            if (done) begin
                pending <= 1'b0;
                if (is_read) begin
                    shadow[rd_idx] <= i2c_data_out;
                end
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_WAKE_REG;
                    end
                end
                S_WAKE_REG: if (done) state <= S_WAKE_VAL;
                S_WAKE_VAL: begin
                    if (done) begin
                        state      <= S_WAIT_TMR;
                        period_cnt <= PERIOD_LOAD;
                    end
                end
                S_WAIT_TMR: begin
                    // Counter parks at 0 while enable is low.
                    if (period_cnt == '0) begin
                        if (enable) begin
                            state <= S_PTR;
                        end
                    end else begin
                        period_cnt <= period_cnt - 1'b1;
                    end
                end
                S_PTR: if (done) state <= S_RD0;
                S_RD0: if (done) state <= S_RD1;
                S_RD1: if (done) state <= S_RD2;
                S_RD2: if (done) state <= S_RD3;
                S_RD3: if (done) state <= S_RD4;
                S_RD4: if (done) state <= S_RD5;
                S_RD5: if (done) state <= S_PUBLISH;
                S_PUBLISH: begin
                    accel_x      <= {shadow[0], shadow[1]};
                    accel_y      <= {shadow[2], shadow[3]};
                    accel_z      <= {shadow[4], shadow[5]};
                    sample_valid <= 1'b1;
                    state        <= S_WAIT_TMR;
                    period_cnt   <= PERIOD_LOAD;
                end
                S_ERR: begin
                    if (period_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        period_cnt <= period_cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Timeout overrides the per-state hold: abandon the byte and cool down.
            if (expire) begin
                pending    <= 1'b0;
                error      <= 1'b1;
                state      <= S_ERR;
                period_cnt <= PERIOD_LOAD;
            end
        end
    end

endmodule

// File: tb/tb_mpu6050_reader.sv
// -----------------------------------------------------------------------------
// tb_mpu6050_reader
//
// Directed bench for mpu6050_reader with a small behavioural i2c_master model
// (fixed 20-cycle byte latency, optional hang on a chosen command index).
// Every command strobe, sample_valid pulse and error pulse is logged with its
// cycle number; checks compare those logs and the sample outputs against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_mpu6050_reader;

    localparam int unsigned SP  = 200;
    localparam int unsigned TO  = 50;
    localparam int unsigned LAT = 20;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        i2c_avail;
    logic [7:0]  i2c_data_out;
    logic        i2c_avail_data_out;
    logic        i2c_start;
    logic        i2c_rw;
    logic        i2c_stop;
    logic [7:0]  i2c_data_in;
    logic [15:0] accel_x;
    logic [15:0] accel_y;
    logic [15:0] accel_z;
    logic        sample_valid;
    logic        busy;
    logic        error;

    mpu6050_reader #(
        .SAMPLE_PERIOD (SP),
        .TIMEOUT       (TO),
        .PWR_MGMT_VAL  (8'h00),
        .START_REG     (8'h3B)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .i2c_avail          (i2c_avail),
        .i2c_data_out       (i2c_data_out),
        .i2c_avail_data_out (i2c_avail_data_out),
        .i2c_start          (i2c_start),
        .i2c_rw             (i2c_rw),
        .i2c_stop           (i2c_stop),
        .i2c_data_in        (i2c_data_in),
        .accel_x            (accel_x),
        .accel_y            (accel_y),
        .accel_z            (accel_z),
        .sample_valid       (sample_valid),
        .busy               (busy),
        .error              (error)
    );

    typedef struct {
        logic        rw;
        logic        stop;
        logic [7:0]  data;
        int unsigned cycle;
    } cmd_t;

    cmd_t        log_q [$];
    int unsigned sv_q  [$];
    int unsigned err_q [$];
    logic [7:0]  rd_bytes [0:5];
    int          hang_idx;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned n_fail;
    int unsigned prot_err;

    // Master model state
    bit          m_busy;
    bit          m_hang;
    bit          m_rw;
    int unsigned m_el;
    int unsigned m_rd;
    logic        nxt_avail;
    logic        nxt_pulse;
    logic [7:0]  nxt_data;

    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = 1'b1;
            cyc++;
            #5 clk = 1'b0;
        end
    end

    // Master model: outputs change at the falling edge, the strobe is read
    // just after so it is the value the DUT samples at the next rising edge.
    initial begin
        m_busy = 0; m_hang = 0; m_rw = 0; m_el = 0; m_rd = 0; prot_err = 0;
        nxt_avail = 1'b1; nxt_pulse = 1'b0; nxt_data = '0;
        i2c_avail = 1'b1; i2c_avail_data_out = 1'b0; i2c_data_out = '0;
        forever begin
            @(negedge clk);
            i2c_avail          = nxt_avail;
            i2c_avail_data_out = nxt_pulse;
            i2c_data_out       = nxt_data;
            #1;
            if (sample_valid) sv_q.push_back(cyc);
            if (error)        err_q.push_back(cyc);
            nxt_pulse = 1'b0;
            nxt_data  = '0;
            if (reset) begin
                m_busy = 0; m_hang = 0; m_rd = 0;
                nxt_avail = 1'b1;
            end else if (i2c_start) begin
                if (m_busy || !i2c_avail) prot_err++;
                log_q.push_back('{i2c_rw, i2c_stop, i2c_data_in, cyc});
                m_hang = ((int'(log_q.size()) - 1) == hang_idx);
                m_busy = 1; m_rw = i2c_rw; m_el = 0;
                if (!i2c_rw) m_rd = 0;
                nxt_avail = 1'b0;
            end else if (m_busy) begin
                if (m_hang) begin
                    if (hang_idx < 0) begin
                        m_busy = 0; m_hang = 0;
                        nxt_avail = 1'b1;
                    end else begin
                        nxt_avail = 1'b0;
                    end
                end else begin
                    m_el++;
                    if (m_el + 1 == LAT) begin
                        m_busy = 0;
                        nxt_avail = 1'b1;
                        if (m_rw) begin
                            nxt_pulse = 1'b1;
                            nxt_data  = rd_bytes[m_rd % 6];
                            m_rd++;
                        end
                    end else begin
                        nxt_avail = 1'b0;
                    end
                end
            end else begin
                nxt_avail = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t get_cmd(input int i);
        cmd_t c;
        c = '{1'b0, 1'b0, 8'h00, 0};
        if (i < int'(log_q.size())) c = log_q[i];
        return c;
    endfunction

    function automatic int unsigned q_count(input int which);
        case (which)
            0:       return log_q.size();
            1:       return sv_q.size();
            default: return err_q.size();
        endcase
    endfunction

    // which: 0 = command log, 1 = sample_valid log, 2 = error log
    task automatic wait_cnt(input int which, input int unsigned n, input int unsigned budget,
                            input string tag);
        int unsigned k;
        k = 0;
        while (q_count(which) < n && k < budget) begin
            tick();
            k++;
        end
        if (q_count(which) < n) check(tag, q_count(which), n);
    endtask

    cmd_t c;

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        hang_idx = -1;
        reset  = 1'b1;
        enable = 1'b0;
        rd_bytes[0] = 8'h12; rd_bytes[1] = 8'h34; rd_bytes[2] = 8'h80;
        rd_bytes[3] = 8'h00; rd_bytes[4] = 8'hFF; rd_bytes[5] = 8'hFE;
        repeat (3) tick();

        // Reset state
        check("reset_accel_xy", {accel_x, accel_y}, 32'h0);
        check("reset_accel_z", accel_z, 32'h0);
        check("reset_ctrl", {i2c_start, i2c_rw, i2c_stop, sample_valid, busy, error}, 32'h0);
        check("reset_data_in", i2c_data_in, 32'h0);

        // Wake-up sequence
        reset  = 1'b0;
        enable = 1'b1;
        wait_cnt(0, 2, 300, "wake_wait");
        c = get_cmd(0);
        check("wake0_data", c.data, 32'h6B);
        check("wake0_rw_stop", {c.rw, c.stop}, 32'h0);
        c = get_cmd(1);
        check("wake1_data", c.data, 32'h00);
        check("wake1_rw_stop", {c.rw, c.stop}, 32'h1);
        check("wake_spacing", get_cmd(1).cycle - get_cmd(0).cycle, LAT + 1);

        // First burst
        wait_cnt(1, 1, 1200, "burst1_wait");
        check("burst1_cmd_count", log_q.size(), 9);
        c = get_cmd(2);
        check("ptr_data", c.data, 32'h3B);
        check("ptr_rw_stop", {c.rw, c.stop}, 32'h0);
        check("wake_to_ptr", get_cmd(2).cycle - get_cmd(1).cycle, SP + LAT + 1);
        for (int i = 3; i <= 8; i++) begin
            c = get_cmd(i);
            check($sformatf("rd%0d_rw_stop", i - 3), {c.rw, c.stop}, (i == 8) ? 32'h3 : 32'h2);
        end
        check("burst1_x", accel_x, 32'h1234);
        check("burst1_y", accel_y, 32'h8000);
        check("burst1_z", accel_z, 32'hFFFE);
        check("publish_latency", sv_q[0] - get_cmd(8).cycle, LAT + 2);
        rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h02; rd_bytes[2] = 8'h7F;
        rd_bytes[3] = 8'hFF; rd_bytes[4] = 8'h80; rd_bytes[5] = 8'h01;
        tick();
        check("sample_valid_one_cycle", sample_valid, 32'h0);

        // Period from publish to next pointer write
        wait_cnt(0, 10, 400, "period_wait");
        check("period_ptr_data", get_cmd(9).data, 32'h3B);
        check("period_cycles", get_cmd(9).cycle - sv_q[0], SP);

        // Second burst
        wait_cnt(1, 2, 400, "burst2_wait");
        check("burst2_x", accel_x, 32'h0102);
        check("burst2_y", accel_y, 32'h7FFF);
        check("burst2_z", accel_z, 32'h8001);
        rd_bytes[0] = 8'hAA; rd_bytes[1] = 8'h55; rd_bytes[2] = 8'h00;
        rd_bytes[3] = 8'h01; rd_bytes[4] = 8'hC0; rd_bytes[5] = 8'h00;

        // Drop enable during RD3 of the third burst
        wait_cnt(0, 21, 600, "rd3_wait");
        enable = 1'b0;
        wait_cnt(1, 3, 400, "burst3_wait");
        check("burst3_x", accel_x, 32'hAA55);
        check("burst3_y", accel_y, 32'h0001);
        check("burst3_z", accel_z, 32'hC000);
        check("burst3_rd5_stop", get_cmd(22).stop, 32'h1);
        repeat (600) tick();
        check("disabled_no_cmd", log_q.size(), 23);
        check("disabled_no_sample", sv_q.size(), 3);
        check("disabled_not_busy", busy, 32'h0);

        // Timeout: master hangs on RD2 of the fourth burst
        hang_idx = 26;
        enable   = 1'b1;
        wait_cnt(2, 1, 600, "error_wait");
        check("hang_cmd_is_read", get_cmd(26).rw, 32'h1);
        check("error_delay", err_q[0] - get_cmd(26).cycle, TO);
        check("error_keep_x", accel_x, 32'hAA55);
        check("error_keep_z", accel_z, 32'hC000);
        check("error_busy", busy, 32'h1);
        tick();
        check("error_one_cycle", error, 32'h0);
        hang_idx = -1;
        wait_cnt(0, 28, 600, "rewake_wait");
        c = get_cmd(27);
        check("rewake_data", c.data, 32'h6B);
        check("rewake_rw_stop", {c.rw, c.stop}, 32'h0);
        check("rewake_delay", c.cycle - err_q[0], SP + 1);
        check("error_no_sample", sv_q.size(), 3);

        // Reset during RD4
        wait_cnt(0, 35, 1200, "rd4_wait");
        check("rd4_is_read", get_cmd(34).rw, 32'h1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("midreset_accel_xy", {accel_x, accel_y}, 32'h0);
        check("midreset_accel_z", accel_z, 32'h0);
        check("midreset_ctrl", {i2c_start, sample_valid, busy, error}, 32'h0);
        reset = 1'b0;
        wait_cnt(0, 36, 100, "postreset_wait");
        c = get_cmd(35);
        check("postreset_data", c.data, 32'h6B);
        check("postreset_rw_stop", {c.rw, c.stop}, 32'h0);

        check("protocol_violations", prot_err, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
